roi_frame_sequencer: RTL and testbench

Per-frame controller between the ROI extractor and the downstream qubit classifier. It arms on a frame boundary and accepts ROI write strobes only while a frame is in progress. Captured ROIs are buffered in a small FIFO and handed downstream over a valid/ready handshake. At frame end it drains the FIFO and reports per-frame completion, capture count, missing-qubit and overflow status.

---
 rtl/params_pkg.sv | 21 ++
 rtl/roi_fifo.sv | 49 ++++
 rtl/roi_frame_sequencer.sv | 136 +++++++++++++
 tb/tb_roi_frame_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/params_pkg.sv
// params_pkg: shared widths, counts and the frame-sequencer state encoding.
`default_nettype none

package params_pkg;

  localparam int NUM_QUBITS     = 4;
  localparam int QUBIT_ID_WIDTH = 3;
  localparam int ROI_BITS       = 9 * 8;
  localparam int ROI_FIFO_DEPTH = 8;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_ARMED,
    SEQ_CAPTURE,
    SEQ_DRAIN,
    SEQ_REPORT
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/roi_fifo.sv
// roi_fifo: synchronous first-word-fall-through buffer with a registered head.
`default_nettype none

module roi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/roi_frame_sequencer.sv
// roi_frame_sequencer: per-frame ROI capture control, buffering and status reporting.
`default_nettype none

module roi_frame_sequencer
  import params_pkg::*;
#(
  parameter int NUM_QUBITS     = params_pkg::NUM_QUBITS,
  parameter int FIFO_DEPTH     = params_pkg::ROI_FIFO_DEPTH,
  parameter int ROI_BITS       = params_pkg::ROI_BITS,
  parameter int QUBIT_ID_WIDTH = params_pkg::QUBIT_ID_WIDTH
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_arm,
  input  logic                      i_continuous,
  input  logic                      i_sync_fval,
  input  logic                      i_roi_we,
  input  logic [ROI_BITS-1:0]       i_roi_flat,
  input  logic [QUBIT_ID_WIDTH-1:0] i_roi_qubit,
  output logic                      o_roi_valid,
  input  logic                      i_roi_ready,
  output logic [ROI_BITS-1:0]       o_roi_flat,
  output logic [QUBIT_ID_WIDTH-1:0] o_roi_qubit,
  output logic                      o_frame_done,
  output logic [QUBIT_ID_WIDTH:0]   o_capture_count,
  output logic                      o_missing,
  output logic                      o_overflow,
  output logic                      o_busy
);

  localparam logic [QUBIT_ID_WIDTH:0] NUM_Q_W = (QUBIT_ID_WIDTH + 1)'(NUM_QUBITS);

  seq_state_t                          state;
  logic                                fval_q;
  logic [NUM_QUBITS-1:0]               seen;
  logic [QUBIT_ID_WIDTH:0]             count;
  logic                                ovf;
  logic                                fifo_full;
  logic                                fifo_empty;
  logic [ROI_BITS+QUBIT_ID_WIDTH-1:0]  fifo_head;
  logic                                fval_rise;
  logic                                fval_fall;
  logic                                pop;
  logic                                push_req;
  logic [NUM_QUBITS-1:0]               qubit_hot;
  logic                                is_new;

  assign fval_rise   = i_sync_fval & ~fval_q;
  assign fval_fall   = ~i_sync_fval & fval_q;
  assign o_roi_valid = ~fifo_empty;
  assign pop         = o_roi_valid & i_roi_ready;
  assign push_req    = i_roi_we && (state == SEQ_CAPTURE) && ({1'b0, i_roi_qubit} < NUM_Q_W);
  assign qubit_hot   = NUM_QUBITS'(1) << i_roi_qubit;
  assign is_new      = |(qubit_hot & ~seen);
  assign {o_roi_qubit, o_roi_flat} = fifo_head;

  // The FIFO itself refuses a push when full without a pop; ovf mirrors that decision.
  roi_fifo #(
    .WIDTH (ROI_BITS + QUBIT_ID_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push_req),
    .push_data ({i_roi_qubit, i_roi_flat}),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= SEQ_IDLE;
      fval_q          <= 1'b0;
      seen            <= '0;
      count           <= '0;
      ovf             <= 1'b0;
      o_frame_done    <= 1'b0;
      o_capture_count <= '0;
      o_missing       <= 1'b0;
      o_overflow      <= 1'b0;
      o_busy          <= 1'b0;
    end else begin
      fval_q       <= i_sync_fval;
      o_frame_done <= 1'b0;

      if (push_req) begin
        seen <= seen | qubit_hot;
        if (is_new) count <= count + 1'b1;
        if (fifo_full && !pop) ovf <= 1'b1;
      end

      case (state)
        SEQ_IDLE: begin
          if (i_arm) state <= SEQ_ARMED;
        end
        SEQ_ARMED: begin
          if (fval_rise) begin
            state  <= SEQ_CAPTURE;
            o_busy <= 1'b1;
            seen   <= '0;
            count  <= '0;
            ovf    <= 1'b0;
          end else if (!i_arm) begin
            state <= SEQ_IDLE;
          end
        end
        SEQ_CAPTURE: begin
          if (fval_fall) state <= SEQ_DRAIN;
        end
        SEQ_DRAIN: begin
          // Status is registered on entry so it lines up with the REPORT cycle.
          if (fifo_empty) begin
            state           <= SEQ_REPORT;
            o_frame_done    <= 1'b1;
            o_capture_count <= count;
            o_missing       <= (count != NUM_Q_W);
            o_overflow      <= ovf;
          end
        end
        SEQ_REPORT: begin
          state  <= i_continuous ? SEQ_ARMED : SEQ_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= SEQ_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_roi_frame_sequencer.sv
// tb_roi_frame_sequencer: directed self-checking bench for the frame sequencer.
`default_nettype none

module tb_roi_frame_sequencer;
  import params_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        continuous;
  logic        fval;
  logic        we;
  logic [71:0] flat_in;
  logic [2:0]  qubit_in;
  logic        valid;
  logic        ready;
  logic [71:0] flat_out;
  logic [2:0]  qubit_out;
  logic        frame_done;
  logic [3:0]  cap_count;
  logic        missing;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  roi_frame_sequencer dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_arm           (arm),
    .i_continuous    (continuous),
    .i_sync_fval     (fval),
    .i_roi_we        (we),
    .i_roi_flat      (flat_in),
    .i_roi_qubit     (qubit_in),
    .o_roi_valid     (valid),
    .i_roi_ready     (ready),
    .o_roi_flat      (flat_out),
    .o_roi_qubit     (qubit_out),
    .o_frame_done    (frame_done),
    .o_capture_count (cap_count),
    .o_missing       (missing),
    .o_overflow      (overflow),
    .o_busy          (busy)
  );

  function automatic logic [71:0] pay(input int n);
    logic [7:0] b;
    b = n[7:0];
    return {9{b}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int q, input int n);
    we       = 1'b1;
    qubit_in = q[2:0];
    flat_in  = pay(n);
    tick();
  endtask

  // Waits (bounded) for the frame_done pulse; a timeout is itself a failed check.
  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (frame_done !== 1'b1 && k < 30) begin
      tick();
      k++;
    end
    chk(tag, 80'(frame_done), 80'(1'b1));
  endtask

  initial begin
    rst = 1'b1; arm = 1'b1; continuous = 1'b1; fval = 1'b0; we = 1'b0;
    flat_in = '0; qubit_in = '0; ready = 1'b1;
    tick(); tick();
    chk("rst_valid", 80'(valid), 80'(0));
    chk("rst_flat", 80'(flat_out), 80'(0));
    chk("rst_qubit", 80'(qubit_out), 80'(0));
    chk("rst_done", 80'(frame_done), 80'(0));
    chk("rst_count", 80'(cap_count), 80'(0));
    chk("rst_missing", 80'(missing), 80'(0));
    chk("rst_overflow", 80'(overflow), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    rst = 1'b0;
    tick(); tick();

    // Frame 1: qubits 0..3 streamed straight through
    fval = 1'b1; tick(); tick();
    for (int i = 0; i < 4; i++) begin
      wr(i, 16 + i);
      chk("f1_valid", 80'(valid), 80'(1));
      chk("f1_qubit", 80'(qubit_out), 80'(i));
      chk("f1_flat", 80'(flat_out), 80'(pay(16 + i)));
    end
    we = 1'b0; fval = 1'b0;
    wait_done("f1_done");
    chk("f1_count", 80'(cap_count), 80'(4));
    chk("f1_missing", 80'(missing), 80'(0));
    chk("f1_overflow", 80'(overflow), 80'(0));
    tick();
    chk("f1_done_pulse", 80'(frame_done), 80'(0));
    chk("f1_hold_count", 80'(cap_count), 80'(4));

    // Frame 2: qubits 0, 2, 2
    fval = 1'b1; tick(); tick();
    wr(0, 32); chk("f2_q0", 80'(qubit_out), 80'(0));
    wr(2, 33); chk("f2_q2a", 80'(qubit_out), 80'(2));
    wr(2, 34); chk("f2_q2b", 80'(flat_out), 80'(pay(34)));
    we = 1'b0; fval = 1'b0;
    wait_done("f2_done");
    chk("f2_count", 80'(cap_count), 80'(2));
    chk("f2_missing", 80'(missing), 80'(1));
    chk("f2_overflow", 80'(overflow), 80'(0));
    tick();

    // Frame 3: ready low, 9 writes into 8 entries
    ready = 1'b0;
    fval = 1'b1; tick(); tick();
    for (int i = 0; i < 9; i++) wr(i % 4, 48 + i);
    chk("f3_head_stable", 80'(flat_out), 80'(pay(48)));
    chk("f3_valid", 80'(valid), 80'(1));
    we = 1'b0; fval = 1'b0;
    tick(); tick(); tick();
    chk("f3_state_drain", 80'(dut.state), 80'(SEQ_DRAIN));
    chk("f3_busy", 80'(busy), 80'(1));
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("f3_pop", 80'(flat_out), 80'(pay(48 + i)));
      if (i == 7) chk("f3_still_drain", 80'(dut.state), 80'(SEQ_DRAIN));
      tick();
    end
    chk("f3_empty", 80'(valid), 80'(0));
    wait_done("f3_done");
    chk("f3_count", 80'(cap_count), 80'(4));
    chk("f3_overflow", 80'(overflow), 80'(1));
    chk("f3_missing", 80'(missing), 80'(0));
    tick();

    // Frame 4: full FIFO with push and pop in the same cycle
    ready = 1'b0;
    fval = 1'b1; tick(); tick();
    for (int i = 0; i < 8; i++) wr(i % 4, 64 + i);
    ready = 1'b1;
    wr(0, 72);
    we = 1'b0; ready = 1'b0;
    chk("f4_head_after", 80'(flat_out), 80'(pay(65)));
    fval = 1'b0; ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("f4_pop", 80'(flat_out), 80'(pay(65 + i)));
      tick();
    end
    wait_done("f4_done");
    chk("f4_overflow", 80'(overflow), 80'(0));
    chk("f4_count", 80'(cap_count), 80'(4));
    tick();

    // Writes outside CAPTURE, then an out-of-range qubit index
    wr(1, 80); wr(1, 81);
    we = 1'b0;
    chk("armed_no_push", 80'(valid), 80'(0));
    fval = 1'b1; tick(); tick();
    wr(7, 82);
    chk("q7_no_push", 80'(valid), 80'(0));
    wr(1, 83);
    chk("q1_push", 80'(qubit_out), 80'(1));
    we = 1'b0; fval = 1'b0;
    wait_done("f5_done");
    chk("f5_count", 80'(cap_count), 80'(1));
    chk("f5_missing", 80'(missing), 80'(1));
    tick();

    // Reset in the middle of a capture with three entries queued
    ready = 1'b0;
    fval = 1'b1; tick(); tick();
    wr(0, 96); wr(1, 97); wr(2, 98);
    we = 1'b0;
    chk("pre_rst_valid", 80'(valid), 80'(1));
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 80'(valid), 80'(0));
    chk("mid_rst_state", 80'(dut.state), 80'(SEQ_IDLE));
    chk("mid_rst_count", 80'(cap_count), 80'(0));
    chk("mid_rst_missing", 80'(missing), 80'(0));
    chk("mid_rst_overflow", 80'(overflow), 80'(0));
    chk("mid_rst_busy", 80'(busy), 80'(0));
    chk("mid_rst_flat", 80'(flat_out), 80'(0));
    rst = 1'b0;
    tick(); tick(); tick();
    chk("post_rst_no_capture", 80'(dut.state), 80'(SEQ_ARMED));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
